// File: rtl/gcd_job_arbiter.sv
// Round-robin front end that shares one GCD engine between NREQ requesters.
// Zero operands bypass the engine; a timeout aborts a job whose engine never reports done.
module gcd_job_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [W-1:0]      eng_a,
    output logic [W-1:0]      eng_b,
    output logic              eng_start,
    input  logic              eng_done,
    input  logic [W-1:0]      eng_result
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_MASK,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     ptr_reg, ptr_next;
    logic [PW-1:0]     owner_reg, owner_next;
    logic [NREQ-1:0]   gnt_reg, gnt_next;
    logic [NREQ-1:0]   rsp_valid_reg, rsp_valid_next;
    logic [W-1:0]      rsp_data_reg, rsp_data_next;
    logic              rsp_err_reg, rsp_err_next;
    logic              busy_reg, busy_next;
    logic [W-1:0]      eng_a_reg, eng_a_next;
    logic [W-1:0]      eng_b_reg, eng_b_next;
    logic              eng_start_reg, eng_start_next;
    logic [TO_W-1:0]   tcnt_reg, tcnt_next;

    logic [W-1:0]      op_a [NREQ];
    logic [W-1:0]      op_b [NREQ];
    logic              win_found;
    logic [PW-1:0]     win_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign op_a[gi] = req_a[gi*W +: W];
            assign op_b[gi] = req_b[gi*W +: W];
        end
    endgenerate

    // Index arithmetic modulo NREQ, which need not be a power of two.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // First pending request at or after the round-robin pointer.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req[wrap_add(ptr_reg, k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(ptr_reg, k);
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        owner_next     = owner_reg;
        gnt_next       = '0;
        rsp_valid_next = rsp_valid_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_err_next   = rsp_err_reg;
        eng_a_next     = eng_a_reg;
        eng_b_next     = eng_b_reg;
        eng_start_next = 1'b0;
        tcnt_next      = tcnt_reg;

        case (state_reg)
            S_IDLE: begin
                if (win_found) begin
                    gnt_next   = onehot(win_idx);
                    eng_a_next = op_a[win_idx];
                    eng_b_next = op_b[win_idx];
                    owner_next = win_idx;
                    if (op_a[win_idx] == '0 || op_b[win_idx] == '0) begin
                        rsp_data_next  = op_a[win_idx] | op_b[win_idx];
                        rsp_err_next   = 1'b0;
                        rsp_valid_next = onehot(win_idx);
                        state_next     = S_RESP;
                    end else begin
                        state_next = S_START;
                    end
                end
            end
            S_START: begin
                eng_start_next = 1'b1;
                tcnt_next      = '0;
                state_next     = S_MASK;
            end
            // The engine sees start only at the end of this cycle, so done may still be stale here.
            S_MASK: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    rsp_data_next  = eng_result;
                    rsp_err_next   = 1'b0;
                    rsp_valid_next = onehot(owner_reg);
                    state_next     = S_RESP;
                end else if (tcnt_reg == TO_W'(TIMEOUT - 1)) begin
                    rsp_data_next  = '0;
                    rsp_err_next   = 1'b1;
                    rsp_valid_next = onehot(owner_reg);
                    state_next     = S_RESP;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready[owner_reg]) begin
                    rsp_valid_next = '0;
                    ptr_next       = wrap_add(owner_reg, 1);
                    state_next     = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            ptr_reg       <= '0;
            owner_reg     <= '0;
            gnt_reg       <= '0;
            rsp_valid_reg <= '0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            eng_a_reg     <= '0;
            eng_b_reg     <= '0;
            eng_start_reg <= 1'b0;
            tcnt_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            owner_reg     <= owner_next;
            gnt_reg       <= gnt_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_err_reg   <= rsp_err_next;
            busy_reg      <= busy_next;
            eng_a_reg     <= eng_a_next;
            eng_b_reg     <= eng_b_next;
            eng_start_reg <= eng_start_next;
            tcnt_reg      <= tcnt_next;
        end
    end

    assign gnt       = gnt_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;
    assign busy      = busy_reg;
    assign eng_a     = eng_a_reg;
    assign eng_b     = eng_b_reg;
    assign eng_start = eng_start_reg;

endmodule
